// File: rtl/cnn_counter_pkg.sv
// Shared definitions for the counter family.
// Provides the FSM state encoding used by count_down_neg.
package cnn_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } cd_state_e;

   localparam int unsigned CD_BITWIDTH_DEFAULT = 10;

endpackage

// File: rtl/count_down_neg.sv
// count_down_neg: loadable down-counter clocked on the falling edge of
// COUNTDOWN_Clk, with IDLE/RUN/DONE sequencing, synchronous abort and a
// registered one-cycle terminal pulse.
// Optional feature macro: COUNTDOWN_AUTORELOAD_EN -- on reaching the terminal
// count the run restarts from the last loaded value instead of stopping.
module count_down_neg
   import cnn_counter_pkg::*;
#(
   parameter int unsigned BITWIDTH = CD_BITWIDTH_DEFAULT
) (
   input  logic                COUNTDOWN_Clk,
   input  logic                COUNTDOWN_Clr,
   input  logic                COUNTDOWN_Load_Valid,
   input  logic [BITWIDTH-1:0] COUNTDOWN_Load_Number,
   output logic                COUNTDOWN_Load_Ready,
   input  logic                COUNTDOWN_En,
   input  logic                COUNTDOWN_Abort,
   output logic [BITWIDTH-1:0] COUNTDOWN_Out,
   output logic                COUNTDOWN_Busy,
   output logic                COUNTDOWN_Done_Pulse,
   output logic                COUNTDOWN_Zero_Flag
);

   cd_state_e           r_state;
   cd_state_e           w_state_nxt;
   logic [BITWIDTH-1:0] r_count;
   logic [BITWIDTH-1:0] w_count_nxt;
   logic [BITWIDTH-1:0] r_reload;
   logic [BITWIDTH-1:0] w_reload_nxt;
   logic                r_done_pulse;
   logic                w_done_pulse_nxt;
   logic                w_load_ready;
   logic                w_load_accept;

   assign w_load_ready  = (r_state != ST_RUN) && !COUNTDOWN_Abort;
   assign w_load_accept = COUNTDOWN_Load_Valid && w_load_ready;

   // State, count, reload value and terminal pulse, all on the falling edge.
   always_ff @(negedge COUNTDOWN_Clk or negedge COUNTDOWN_Clr) begin
      if (!COUNTDOWN_Clr) begin
         r_state      <= ST_IDLE;
         r_count      <= '0;
         r_reload     <= '0;
         r_done_pulse <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_count      <= w_count_nxt;
         r_reload     <= w_reload_nxt;
         r_done_pulse <= w_done_pulse_nxt;
      end
   end

   // Next state and next count: abort beats load, load beats decrement.
   always_comb begin
      w_state_nxt      = r_state;
      w_count_nxt      = r_count;
      w_reload_nxt     = r_reload;
      w_done_pulse_nxt = 1'b0;
      if (COUNTDOWN_Abort) begin
         w_state_nxt = ST_IDLE;
         w_count_nxt = '0;
      end else if (w_load_accept) begin
         w_count_nxt  = COUNTDOWN_Load_Number;
         w_reload_nxt = COUNTDOWN_Load_Number;
         if (COUNTDOWN_Load_Number != '0) begin
            w_state_nxt = ST_RUN;
         end else begin
            // A zero load finishes immediately, even with auto-reload.
            w_state_nxt      = ST_DONE;
            w_done_pulse_nxt = 1'b1;
         end
      end else begin
         case (r_state)
            ST_RUN: begin
               if (COUNTDOWN_En) begin
                  if (r_count > BITWIDTH'(1)) begin
                     w_count_nxt = r_count - BITWIDTH'(1);
                  end else begin
                     w_done_pulse_nxt = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                     w_count_nxt = r_reload;
                     w_state_nxt = ST_RUN;
`else
                     w_count_nxt = '0;
                     w_state_nxt = ST_DONE;
`endif
                  end
               end
            end
            ST_DONE: begin
               w_count_nxt = '0;
            end
            ST_IDLE: begin
               w_count_nxt = r_count;
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_count_nxt = '0;
            end
         endcase
      end
   end

   // Outputs decoded from the registered state and count.
   always_comb begin
      COUNTDOWN_Load_Ready = w_load_ready;
      COUNTDOWN_Busy       = (r_state == ST_RUN);
      COUNTDOWN_Out        = r_count;
      COUNTDOWN_Zero_Flag  = (r_count == '0);
      COUNTDOWN_Done_Pulse = r_done_pulse;
   end

endmodule

// File: tb/tb_count_down_neg.sv
// Bench for count_down_neg: table-driven vectors pushed to a scoreboard queue
// at drive time and popped after the falling edge, plus hand sequences for
// reset and asynchronous clear mid-run. Honors COUNTDOWN_AUTORELOAD_EN.
module tb_count_down_neg;

   localparam int W = 10;

   typedef struct {
      logic         lv;
      logic [W-1:0] ln;
      logic         en;
      logic         ab;
      logic [W-1:0] e_out;
      logic         e_busy;
      logic         e_pulse;
      logic         e_ready;
   } vec_t;

   logic         clk;
   logic         clr_n;
   logic         load_valid;
   logic [W-1:0] load_number;
   logic         load_ready;
   logic         en;
   logic         abort_i;
   logic [W-1:0] out_v;
   logic         busy;
   logic         done_pulse;
   logic         zero_flag;

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];
   vec_t exp_q[$];

   count_down_neg #(.BITWIDTH(W)) dut (
      .COUNTDOWN_Clk         (clk),
      .COUNTDOWN_Clr         (clr_n),
      .COUNTDOWN_Load_Valid  (load_valid),
      .COUNTDOWN_Load_Number (load_number),
      .COUNTDOWN_Load_Ready  (load_ready),
      .COUNTDOWN_En          (en),
      .COUNTDOWN_Abort       (abort_i),
      .COUNTDOWN_Out         (out_v),
      .COUNTDOWN_Busy        (busy),
      .COUNTDOWN_Done_Pulse  (done_pulse),
      .COUNTDOWN_Zero_Flag   (zero_flag)
   );

   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void add(input logic lv, input logic [W-1:0] ln,
                               input logic e, input logic ab,
                               input logic [W-1:0] eo, input logic eb,
                               input logic ep, input logic er);
      vec_t v;
      v.lv = lv; v.ln = ln; v.en = e; v.ab = ab;
      v.e_out = eo; v.e_busy = eb; v.e_pulse = ep; v.e_ready = er;
      vecs.push_back(v);
   endfunction

   task automatic cmp(input string nm, input int tag, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s step %0d: got %0d want %0d", nm, tag, got, want);
      end
   endtask

   task automatic check_all(input int tag, input logic [W-1:0] eo, input logic eb,
                            input logic ep, input logic er);
      cmp("out",   tag, int'(out_v),      int'(eo));
      cmp("busy",  tag, int'(busy),       int'(eb));
      cmp("pulse", tag, int'(done_pulse), int'(ep));
      cmp("zero",  tag, int'(zero_flag),  int'(eo == '0));
      cmp("ready", tag, int'(load_ready), int'(er));
   endtask

   // Called at a rising edge: drive, push expectation, let the falling edge
   // act, then compare at the next rising edge with inputs still applied.
   task automatic apply(input vec_t v, input int tag);
      vec_t e;
      load_valid  = v.lv;
      load_number = v.ln;
      en          = v.en;
      abort_i     = v.ab;
      exp_q.push_back(v);
      @(negedge clk);
      @(posedge clk);
      if (exp_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL scoreboard step %0d: got empty queue want entry", tag);
      end else begin
         e = exp_q.pop_front();
         check_all(tag, e.e_out, e.e_busy, e.e_pulse, e.e_ready);
      end
   endtask

   task automatic run_vecs(input int base);
      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], base + i);
      vecs.delete();
   endtask

   initial begin
      clr_n = 1'b0; load_valid = 1'b0; load_number = '0; en = 1'b0; abort_i = 1'b0;
      #2;
      check_all(0, '0, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      @(posedge clk);
      clr_n = 1'b1;

`ifndef COUNTDOWN_AUTORELOAD_EN
      // load 3, En high
      add(1, 3,   1, 0, 3, 1, 0, 0);
      add(0, 0,   1, 0, 2, 1, 0, 0);
      add(0, 0,   1, 0, 1, 1, 0, 0);
      add(0, 0,   1, 0, 0, 0, 1, 1);
      add(0, 0,   1, 0, 0, 0, 0, 1);
      // back-to-back load 5 from DONE, En toggling; load during RUN ignored
      add(1, 5,   0, 0, 5, 1, 0, 0);
      add(0, 0,   1, 0, 4, 1, 0, 0);
      add(1, 7,   0, 0, 4, 1, 0, 0);
      add(0, 0,   1, 0, 3, 1, 0, 0);
      add(0, 0,   0, 0, 3, 1, 0, 0);
      add(0, 0,   1, 0, 2, 1, 0, 0);
      add(0, 0,   0, 0, 2, 1, 0, 0);
      add(0, 0,   1, 0, 1, 1, 0, 0);
      add(0, 0,   0, 0, 1, 1, 0, 0);
      add(0, 0,   1, 0, 0, 0, 1, 1);
      add(0, 0,   0, 0, 0, 0, 0, 1);
      // load 0 twice: one pulse each, never busy
      add(1, 0,   1, 0, 0, 0, 1, 1);
      add(0, 0,   1, 0, 0, 0, 0, 1);
      add(1, 0,   0, 0, 0, 0, 1, 1);
      add(0, 0,   0, 0, 0, 0, 0, 1);
      // load 4, abort at 2 with a competing load
      add(1, 4,   1, 0, 4, 1, 0, 0);
      add(0, 0,   1, 0, 3, 1, 0, 0);
      add(0, 0,   1, 0, 2, 1, 0, 0);
      add(1, 9,   1, 1, 0, 0, 0, 0);
      add(0, 0,   1, 0, 0, 0, 0, 1);
      // abort beats the terminal decrement
      add(1, 1,   1, 0, 1, 1, 0, 0);
      add(0, 0,   1, 1, 0, 0, 0, 0);
      add(0, 0,   1, 0, 0, 0, 0, 1);
      // full-scale load
      add(1, 1023, 1, 0, 1023, 1, 0, 0);
      add(0, 0,   1, 0, 1022, 1, 0, 0);
      add(0, 0,   1, 1, 0, 0, 0, 0);
`else
      // auto-reload: load 2, En high -> 2,1,2,1,2,1
      add(1, 2,   1, 0, 2, 1, 0, 0);
      add(0, 0,   1, 0, 1, 1, 0, 0);
      add(0, 0,   1, 0, 2, 1, 1, 0);
      add(0, 0,   1, 0, 1, 1, 0, 0);
      add(0, 0,   1, 0, 2, 1, 1, 0);
      add(0, 0,   1, 0, 1, 1, 0, 0);
      add(1, 5,   0, 0, 1, 1, 0, 0);
      add(0, 0,   1, 1, 0, 0, 0, 0);
      add(0, 0,   1, 0, 0, 0, 0, 1);
      // load 0 still finishes in DONE with one pulse
      add(1, 0,   1, 0, 0, 0, 1, 1);
      add(0, 0,   1, 0, 0, 0, 0, 1);
      // load 1 reloads to 1 on every enabled edge
      add(1, 1,   1, 0, 1, 1, 0, 0);
      add(0, 0,   1, 0, 1, 1, 1, 0);
      add(0, 0,   0, 0, 1, 1, 0, 0);
      add(0, 0,   1, 1, 0, 0, 0, 0);
`endif
      run_vecs(100);

      // clear mid-run at 6 of 8
      add(1, 8,   1, 0, 8, 1, 0, 0);
      add(0, 0,   1, 0, 7, 1, 0, 0);
      add(0, 0,   1, 0, 6, 1, 0, 0);
      run_vecs(200);
      clr_n = 1'b0;
      #1;
      check_all(300, '0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      @(posedge clk);
      check_all(301, '0, 1'b0, 1'b0, 1'b1);
      clr_n = 1'b1;
      add(0, 0,   1, 0, 0, 0, 0, 1);
      add(1, 2,   1, 0, 2, 1, 0, 0);
      add(0, 0,   1, 0, 1, 1, 0, 0);
`ifndef COUNTDOWN_AUTORELOAD_EN
      add(0, 0,   1, 0, 0, 0, 1, 1);
      add(0, 0,   1, 0, 0, 0, 0, 1);
`else
      add(0, 0,   1, 0, 2, 1, 1, 0);
      add(0, 0,   1, 1, 0, 0, 0, 0);
`endif
      run_vecs(400);

      if (exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL scoreboard drain: got %0d entries want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
